// File: rtl/mips_defines.sv
// -----------------------------------------------------------------------------
// mips_defines
// Shared definitions for the MIPS memory-stage data bridge:
//   - bridge_state_t : bus-bridge FSM state encoding
//   - SZ_BYTE/SZ_HALF/SZ_WORD : access-size codes carried on memsizeM/data_size
//   - KSEG_MASK : strips the segment bits from a kseg0/kseg1 virtual address
//   - is_kseg01() : true for virtual addresses in 0x8000_0000..0xBFFF_FFFF
// -----------------------------------------------------------------------------
package mips_defines;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } bridge_state_t;

    localparam logic [1:0]  SZ_BYTE   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_WORD   = 2'd2;

    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    // kseg0 and kseg1 share the top two address bits 2'b10.
    function automatic logic is_kseg01(input logic [31:0] vaddr);
        return (vaddr[31:30] == 2'b10);
    endfunction

endpackage

// File: rtl/addr_map.sv
// -----------------------------------------------------------------------------
// addr_map
// Combinational virtual-to-physical translation for the data port.
// With MAP_KSEG = 1, kseg0/kseg1 addresses lose their segment bits (upper three
// bits cleared); every other address, and all addresses when MAP_KSEG = 0,
// pass through unchanged.
// Ports:
//   vaddr  in  32  virtual address from the M stage
//   paddr  out 32  physical address for the bus
// -----------------------------------------------------------------------------
module addr_map
    import mips_defines::*;
#(
    parameter logic MAP_KSEG = 1'b1
)
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    // Segment translation: unmapped kseg regions alias the low 512 MB.
    always_comb begin
        if (MAP_KSEG && is_kseg01(vaddr)) begin
            paddr = vaddr & KSEG_MASK;
        end else begin
            paddr = vaddr;
        end
    end

endmodule

// File: rtl/data_sram_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_bridge
// Converts each M-stage load/store of the pipelined MIPS core into one
// transaction on a split-handshake (addr_ok / data_ok) SRAM-like bus, stalls
// the pipeline while the access is outstanding, and returns load data in the
// cycle the access completes. Returned data is held in a register so it stays
// valid while some other stall source keeps the pipeline frozen.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   memenM, memwriteM         M-stage access enable, 1 = store
//   sig_write[3:0]            store byte strobes
//   memsizeM[1:0]             access size (byte/half/word)
//   aluoutM[31:0]             virtual address
//   writedataM[31:0]          lane-aligned store data
//   stall_ext                 pipeline stalled by another source
//   readdataM[31:0]           load data to the M/W register
//   stall_mem                 access outstanding, freeze F..M
//   data_req/wr/size/addr/wstrb/wdata   bus request side
//   data_addr_ok, data_data_ok, data_rdata  bus response side
// -----------------------------------------------------------------------------
module data_sram_bridge
    import mips_defines::*;
#(
    parameter logic MAP_KSEG = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [3:0]  sig_write,
    input  logic [1:0]  memsizeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        stall_ext,
    output logic [31:0] readdataM,
    output logic        stall_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    bridge_state_t state_r;
    logic [31:0]   rdata_r;
    logic [31:0]   paddr_s;

    addr_map #(
        .MAP_KSEG (MAP_KSEG)
    ) u_addr_map (
        .vaddr (aluoutM),
        .paddr (paddr_s)
    );

    // Request fields come straight from the M stage; stall_mem freezes them
    // for as long as the request is pending, so no extra capture is needed.
    assign data_wr    = memwriteM;
    assign data_size  = memsizeM;
    assign data_addr  = paddr_s;
    assign data_wstrb = memwriteM ? sig_write : 4'b0000;
    assign data_wdata = writedataM;

    // Transaction FSM plus the register that keeps the last returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    // Responses arriving here are leftovers from before reset.
                    if (memenM) begin
                        state_r <= data_addr_ok ? DATA : ADDR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADDR: begin
                    if (data_addr_ok) begin
                        state_r <= DATA;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                DATA: begin
                    if (data_data_ok) begin
                        rdata_r <= data_rdata;
                        // If the pipeline cannot advance, the same instruction
                        // stays in M; park in HOLD so it is not re-issued.
                        state_r <= stall_ext ? HOLD : IDLE;
                    end else begin
                        state_r <= DATA;
                    end
                end
                HOLD: begin
                    if (!stall_ext) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Bus request, pipeline stall and load-data return.
    always_comb begin
        data_req  = 1'b0;
        stall_mem = 1'b0;
        case (state_r)
            IDLE: begin
                data_req  = memenM;
                stall_mem = memenM;
            end
            ADDR: begin
                data_req  = 1'b1;
                stall_mem = 1'b1;
            end
            DATA: begin
                data_req  = 1'b0;
                stall_mem = ~data_data_ok;
            end
            HOLD: begin
                data_req  = 1'b0;
                stall_mem = 1'b0;
            end
            default: begin
                data_req  = 1'b0;
                stall_mem = 1'b0;
            end
        endcase

        // Forward the bus data in the completing cycle so the load finishes
        // without an extra stall cycle.
        if ((state_r == DATA) && data_data_ok) begin
            readdataM = data_rdata;
        end else begin
            readdataM = rdata_r;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_sram_bridge
// Drives the M-stage side and acts as the bus slave. Every access pushes its
// expected bus request and its read data into queues; an independent monitor
// on the falling edge derives the expected handshake/stall/readdata values
// from those queues and compares them with the DUT.
// -----------------------------------------------------------------------------
module tb_data_sram_bridge;
    import mips_defines::*;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        memenM       = 1'b0;
    logic        memwriteM    = 1'b0;
    logic [3:0]  sig_write    = 4'h0;
    logic [1:0]  memsizeM     = 2'd0;
    logic [31:0] aluoutM      = 32'h0;
    logic [31:0] writedataM   = 32'h0;
    logic        stall_ext    = 1'b0;
    logic [31:0] readdataM;
    logic        stall_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata   = 32'h0;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    int          outstanding  = 0;
    logic [31:0] last_rd      = 32'h0;
    int          vectors      = 0;
    int          miscompares  = 0;
    logic [1:0]  sizes [3]    = '{SZ_BYTE, SZ_HALF, SZ_WORD};

    data_sram_bridge #(.MAP_KSEG(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .sig_write    (sig_write),
        .memsizeM     (memsizeM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .stall_ext    (stall_ext),
        .readdataM    (readdataM),
        .stall_mem    (stall_mem),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    // Reference address map expressed as segment-base subtraction.
    function automatic logic [31:0] ref_paddr(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: expected behaviour from the outstanding-request bookkeeping.
    initial begin
        req_t r;
        logic exp_req;
        logic completing;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_q.delete();
                rd_q.delete();
                outstanding = 0;
                last_rd     = 32'h0;
            end else begin
                exp_req    = (req_q.size() != 0);
                completing = (outstanding != 0) && data_data_ok;
                chk("data_req", {31'h0, data_req}, {31'h0, exp_req});
                chk("stall_mem", {31'h0, stall_mem},
                    {31'h0, exp_req || ((outstanding != 0) && !data_data_ok)});
                if (exp_req) begin
                    r = req_q[0];
                    chk("data_addr", data_addr, r.addr);
                    chk("data_wr", {31'h0, data_wr}, {31'h0, r.wr});
                    chk("data_size", {30'h0, data_size}, {30'h0, r.size});
                    chk("data_wstrb", {28'h0, data_wstrb}, {28'h0, r.strb});
                    chk("data_wdata", data_wdata, r.wdata);
                end
                chk("readdataM", readdataM, completing ? rd_q[0] : last_rd);
                if (completing) begin
                    last_rd     = rd_q.pop_front();
                    outstanding = 0;
                end
                if (exp_req && data_addr_ok) begin
                    void'(req_q.pop_front());
                    outstanding = 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        memenM = 1'b0;
        for (int k = 0; k < n; k++) begin
            aluoutM      = $urandom;
            memwriteM    = 1'($urandom_range(0, 1));
            data_addr_ok = 1'($urandom_range(0, 1));
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata   = $urandom;
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    // One access: aw extra cycles before addr_ok, dw extra DATA cycles before
    // data_ok; with hold set the pipeline stays stalled for 3 cycles total.
    task automatic access(input logic [31:0] a, input logic w, input logic [1:0] sz,
                          input logic [3:0] st, input logic [31:0] wd,
                          input int aw, input int dw, input bit hold, input logic [31:0] rd);
        req_t r;
        memenM     = 1'b1;
        memwriteM  = w;
        memsizeM   = sz;
        aluoutM    = a;
        sig_write  = st;
        writedataM = wd;
        r.addr = ref_paddr(a); r.wr = w; r.size = sz;
        r.strb = w ? st : 4'h0; r.wdata = wd;
        req_q.push_back(r);
        rd_q.push_back(rd);
        data_data_ok = 1'b0;
        for (int i = 0; i <= aw; i++) begin
            data_addr_ok = (i == aw);
            @(posedge clk); #1;
        end
        for (int j = 0; j <= dw; j++) begin
            data_data_ok = (j == dw);
            data_rdata   = (j == dw) ? rd : $urandom;
            data_addr_ok = (j != dw) ? 1'($urandom_range(0, 1)) : 1'b0;
            stall_ext    = hold && (j == dw);
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        if (hold) begin
            repeat (2) begin
                @(posedge clk); #1;
            end
            stall_ext = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        access(32'h8000_0010, 1'b0, SZ_WORD, 4'hF, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        idle(1);
        access(32'hBFC0_0002, 1'b1, SZ_BYTE, 4'b0100, 32'h00AB_0000, 3, 1, 1'b0, 32'h5555_AAAA);
        idle(1);
        access(32'h0040_0000, 1'b0, SZ_WORD, 4'h0, 32'h0, 1, 0, 1'b0, 32'h0BAD_F00D);
        idle(1);
        access(32'h8000_0100, 1'b0, SZ_WORD, 4'h0, 32'h0, 0, 1, 1'b1, 32'h1234_5678);
        access(32'h8000_0104, 1'b0, SZ_WORD, 4'h0, 32'h0, 0, 0, 1'b0, 32'hA5A5_0001);
        access(32'h8000_0108, 1'b0, SZ_HALF, 4'h0, 32'h0, 0, 0, 1'b0, 32'hA5A5_0002);
        idle(1);

        // Reset while the access sits in DATA; a late data_ok must be dropped.
        memenM = 1'b1; memwriteM = 1'b0; memsizeM = SZ_WORD; aluoutM = 32'hA000_0040;
        req_q.push_back('{32'h0000_0040, 1'b0, SZ_WORD, 4'h0, writedataM});
        rd_q.push_back(32'h7777_7777);
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        memenM = 1'b0;
        @(posedge clk); #1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        idle(2);

        for (int n = 0; n < 250; n++) begin
            a = $urandom;
            a[31:29] = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            access(a, w, sizes[$urandom_range(0, 2)], 4'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 4) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

        chk("pending_requests", 32'(req_q.size()), 32'h0);
        chk("outstanding", 32'(outstanding), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Memory-stage bridge between the pipelined MIPS datapath's single-cycle data port (memwriteM, sig_write, aluoutM, writedataM, readdataM) and a split-handshake SRAM-like data bus. It turns each M-stage load or store into one bus transaction and returns load data in the same M-stage cycle the access completes. While the access is outstanding it drives stall_mem into hazard. It performs kseg0/kseg1 address mapping and holds returned data while the rest of the pipeline is still stalled.

## Interface
- MAP_KSEG, 1: when 1, map kseg0/kseg1 addresses to physical addresses; when 0, pass addresses through unchanged.
- clk  in  1  clock; one clock domain, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- memenM  in  1  M-stage instruction is a load or store.
- memwriteM  in  1  1 = store, 0 = load (valid with memenM).
- sig_write  in  4  store byte strobes from write_data; ignored for loads.
- memsizeM  in  2  access size: 0 = byte, 1 = half, 2 = word.
- aluoutM  in  32  virtual address.
- writedataM  in  32  lane-aligned store data.
- stall_ext  in  1  pipeline stalled by another source (divider, fetch).
- readdataM  out  32  load data to the M/W register.
- stall_mem  out  1  access outstanding; hazard freezes F..M.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  equals memsizeM.
- data_addr  out  32  physical address.
- data_wstrb  out  4  equals sig_write on writes, 4'b0000 on reads.
- data_wdata  out  32  equals writedataM.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  read data valid / write done this cycle.
- data_rdata  in  32  read data.

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD. Reset state is IDLE.
- **IDLE**
  - data_req = memenM, combinational.
  - memenM & data_addr_ok -> DATA.
  - memenM & ~data_addr_ok -> ADDR.
  - data_data_ok is ignored, which discards stale responses after reset.
- **ADDR**
  - data_req = 1.
  - data_wr, data_addr, data_size, data_wstrb and data_wdata are held stable; the M-stage inputs are frozen by stall_mem.
  - data_addr_ok -> DATA.
- **DATA**
  - data_req = 0.
  - On data_data_ok, rdata_q <= data_rdata (stores also latch; the value is don't-care).
  - Then stall_ext -> HOLD, else -> IDLE.
- **HOLD**
  - data_req = 0; stall_mem = 0.
  - ~stall_ext -> IDLE.
  - A new request is never issued from HOLD: the M-stage instruction is the same one that already completed.
- stall_mem = (IDLE & memenM) | ADDR | (DATA & ~data_data_ok).
- readdataM = (DATA & data_data_ok) ? data_rdata : rdata_q.
- Address map, applied only when MAP_KSEG = 1: if aluoutM[31:30] == 2'b10 (0x8000_0000-0xBFFF_FFFF), data_addr = {3'b000, aluoutM[28:0]}; otherwise data_addr = aluoutM.
- Exactly one transaction is outstanding at a time. data_addr_ok outside IDLE/ADDR is ignored.

## Timing
- Reset values: state = IDLE; rdata_q = 0; readdataM = 0.
  - After reset, data_req and stall_mem follow memenM combinationally. With memenM = 0 both are 0.
  - data_wr, data_addr, data_size, data_wstrb and data_wdata follow the inputs combinationally.
- Minimum access: addr_ok in the request cycle, data_ok the next cycle.
  - Result is 2 cycles in M and 1 stall cycle.
  - Each extra wait cycle on addr_ok or data_ok adds one stall cycle.
- Back-to-back memory instructions: the next request can be raised in the cycle right after the completing data_ok cycle, because IDLE is re-entered.
- data_data_ok together with stall_ext: stall_mem drops that cycle and the FSM enters HOLD. readdataM = rdata_q until the pipeline advances.
- Reset mid-transaction: the FSM goes to IDLE on the next edge and the bus response is dropped. The bus slave is reset by the same rst.

## Structure
- Shared package (mips_defines): state encoding (IDLE = 0, ADDR = 1, DATA = 2, HOLD = 3), size constants SZ_BYTE / SZ_HALF / SZ_WORD, and KSEG_MASK = 32'h1FFF_FFFF.
- One sub-module, addr_map: combinational virtual-to-physical translation, parameterised by MAP_KSEG.
- The FSM and rdata_q live in the top-level block.

## Test plan
- **Load word, zero wait:** memenM = 1, memwriteM = 0, aluoutM = 32'h8000_0010; addr_ok the same cycle, data_ok next cycle with 32'hDEAD_BEEF.
  - data_addr = 32'h0000_0010; stall_mem high for 1 cycle; readdataM = 32'hDEAD_BEEF in the data_ok cycle.
- **Store byte, slow bus:** sig_write = 4'b0100, aluoutM = 32'hBFC0_0002; addr_ok delayed 3 cycles, data_ok 2 cycles later.
  - data_addr = 32'h1FC0_0002, data_wstrb = 4'b0100, all bus outputs stable while data_req = 1; stall_mem high for 5 cycles.
- **Pass-through:** MAP_KSEG = 1, aluoutM = 32'h0040_0000.
  - data_addr = 32'h0040_0000.
- **HOLD case:** stall_ext = 1 when data_ok returns 32'h1234_5678; stall_ext drops 3 cycles later.
  - No second data_req; readdataM = 32'h1234_5678 throughout; FSM returns to IDLE.
- **Back-to-back:** two consecutive loads.
  - The second data_req rises in the cycle after the first data_ok.
- **Reset in DATA:** rst pulses, then a late data_ok arrives.
  - FSM stays in IDLE; readdataM = 0; stall_mem = 0.
